// File: rtl/uart_rx_fifo_if.sv
// Receive-side bundle between the UART receiver (slave) and its host parser/CPU (master).
// The host drives the serial line, pops and error clear; the receiver returns FIFO head, status and flags.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                             rxd;
  logic                             rd;
  logic                             clr_err;
  logic [DATA_BITS-1:0]             dout;
  logic                             empty;
  logic                             full;
  logic [$clog2(FIFO_DEPTH+1)-1:0]  count;
  logic                             ready;
  logic                             busy;
  logic                             frame_err;
  logic                             parity_err;
  logic                             overrun;
  logic                             irq;

  modport master (
    output rxd, rd, clr_err,
    input  dout, empty, full, count, ready, busy, frame_err, parity_err, overrun, irq
  );

  modport slave (
    input  rxd, rd, clr_err,
    output dout, empty, full, count, ready, busy, frame_err, parity_err, overrun, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampled, 3-sample majority, 5-9 data bits, optional parity) into a FWFT FIFO.
// A word lands in the FIFO one clk after the stop-bit decision; a full FIFO with no pop drops it and flags overrun.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 163,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);
  localparam int TW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic                 rx_meta;
  logic                 rxs;
  logic [3:0]           sc;
  logic [3:0]           bit_idx;
  logic                 s7;
  logic                 s8;
  logic                 maj;
  logic                 exp_par;
  logic                 mid_bit;
  logic [DATA_BITS-1:0] shreg;
  logic                 word_bad;
  logic                 wr_pend;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [CW-1:0]        cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 do_wr;
  logic                 do_rd;
  logic                 ready_q;

  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 overrun_q;
  logic                 frame_set;
  logic                 parity_set;
  logic                 overrun_set;

  assign tick       = (tick_cnt == TW'(CLK_DIV - 1));
  assign maj        = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign exp_par    = (PARITY == 1) ? ~^shreg : ^shreg;
  assign mid_bit    = tick && (sc == 4'd9);

  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == CW'(FIFO_DEPTH));
  assign do_rd      = bus.rd && !fifo_empty;
  assign do_wr      = wr_pend && (!fifo_full || bus.rd);

  assign frame_set   = mid_bit && (state == STOP) && !maj;
  assign parity_set  = mid_bit && (state == PAR) && (maj != exp_par);
  assign overrun_set = wr_pend && fifo_full && !bus.rd;

  // Serial front end and frame FSM; all decisions happen only on tick cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      state    <= IDLE;
      sc       <= '0;
      bit_idx  <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      shreg    <= '0;
      word_bad <= 1'b0;
      wr_pend  <= 1'b0;
    end else begin
      rx_meta  <= bus.rxd;
      rxs      <= rx_meta;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      wr_pend  <= 1'b0;
      if (tick) begin
        sc <= sc + 1'b1;
        if (sc == 4'd7) s7 <= rxs;
        if (sc == 4'd8) s8 <= rxs;
        case (state)
          IDLE: begin
            if (!rxs) begin
              state    <= START;
              sc       <= '0;
              bit_idx  <= '0;
              word_bad <= 1'b0;
            end
          end
          START: begin
            if (sc == 4'd9) state <= maj ? IDLE : DATA;
          end
          DATA: begin
            if (sc == 4'd9) begin
              shreg <= {maj, shreg[DATA_BITS-1:1]};
              if (bit_idx == 4'(DATA_BITS - 1)) state <= (PARITY != 0) ? PAR : STOP;
              else bit_idx <= bit_idx + 1'b1;
            end
          end
          PAR: begin
            if (sc == 4'd9) begin
              if (maj != exp_par) word_bad <= 1'b1;
              state <= STOP;
            end
          end
          STOP: begin
            // Leave half a bit early so a back-to-back start edge is not missed.
            if (sc == 4'd9) begin
              wr_pend <= maj && !word_bad;
              state   <= maj ? IDLE : WAIT_HIGH;
            end
          end
          WAIT_HIGH: begin
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      cnt          <= '0;
      ready_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      ready_q <= do_wr;
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A set event in the same cycle as a clear keeps the flag raised.
      frame_err_q  <= frame_set   | (frame_err_q  & ~bus.clr_err);
      parity_err_q <= parity_set  | (parity_err_q & ~bus.clr_err);
      overrun_q    <= overrun_set | (overrun_q    & ~bus.clr_err);
    end
  end

  assign bus.dout       = fifo_empty ? '0 : mem[rptr];
  assign bus.empty      = fifo_empty;
  assign bus.full       = fifo_full;
  assign bus.count      = cnt;
  assign bus.ready      = ready_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.irq        = !fifo_empty;
endmodule
